bitmap_stroke_gen: RTL and testbench

// Parametrised successor to the flash bitmap-to-pen-position converter.
// - Reads a packed 1-bpp bitmap (DW-bit words) from flash in raster or serpentine order.
// - Crops the bitmap to a programmable window.
// - Emits pen-down/pen-up stroke events through an output FIFO with a valid/ready handshake.
// - Sits between the flash controller and the plotter motion/stroke sequencer.

---
 rtl/bitmap_stroke_gen.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bitmap_stroke_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_stroke_gen.sv
// Scans a 1-bpp flash bitmap (raster or serpentine), crops it to a window and
// emits pen-down/pen-up stroke events through a small valid/ready FIFO.
module bitmap_stroke_gen #(
   parameter int unsigned DW         = 16,
   parameter int unsigned IMG_W      = 384,
   parameter int unsigned IMG_H      = 288,
   parameter int unsigned X_MIN      = 51,
   parameter int unsigned X_MAX      = 329,
   parameter int unsigned Y_MIN      = 16,
   parameter int unsigned Y_MAX      = 269,
   parameter int unsigned CW         = 9,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SERP       = 1
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iStart,
   input  logic          iAbort,
   output logic          oBusy,
   output logic          oFinish,
   output logic          oRD_REQ,
   output logic [19:0]   oRD_ADDR,
   input  logic [DW-1:0] iRD_DATA,
   input  logic          iRD_VALID,
   output logic          oPOS_VALID,
   input  logic          iPOS_READY,
   output logic [CW-1:0] oX,
   output logic [CW-1:0] oY,
   output logic          oDown,
   output logic [19:0]   oPixCnt
);

   localparam int unsigned WPL = IMG_W / DW;
   localparam int unsigned XW  = $clog2(IMG_W) + 1;
   localparam int unsigned YW  = $clog2(IMG_H) + 1;
   localparam int unsigned WW  = $clog2(WPL + 1);
   localparam int unsigned BW  = $clog2(DW);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned NW  = $clog2(FIFO_DEPTH + 1);
   localparam bit          SERP_ON = (SERP != 0);

   typedef enum logic [2:0] {IDLE, FETCH, SCAN, ROWEND, DRAIN, DONE} stateT;

   stateT          state, stateNxt;
   logic [YW-1:0]  line, lineNxt;
   logic [WW-1:0]  wordIdx, wordNxt;
   logic [XW-1:0]  xPos, xNxt;
   logic [BW-1:0]  bitCnt, bitNxt;
   logic [DW-1:0]  shReg, shNxt;
   logic           pen, penNxt;
   logic [CW-1:0]  penX, penXNxt;
   logic           busyNxt, finishNxt, rdReqNxt;
   logic [19:0]    rdAddrNxt, pixCntNxt;

   logic           push, flush, pushDown;
   logic [CW-1:0]  pushX, pushY;

   logic [NW-1:0]  fifoCnt;
   logic [PW-1:0]  pushIdx;
   logic [FIFO_DEPTH-1:0] vld, memD;
   logic [CW-1:0]  memX [FIFO_DEPTH];
   logic [CW-1:0]  memY [FIFO_DEPTH];

   logic           rtlLine, nextRtl, inWin, pix, popC, room, lastWord;
   logic [YW-1:0]  lineInc, yRel;
   logic [XW-1:0]  xRel, startX;
   logic [WW-1:0]  wordStep, startWord;

   function automatic logic [19:0] wordAddr(input logic [YW-1:0] l, input logic [WW-1:0] w);
      return 20'(l) * 20'(WPL) + 20'(w);
   endfunction

   // Wrapping subtraction turns each window test into a single compare.
   assign xRel      = xPos - XW'(X_MIN);
   assign yRel      = line - YW'(Y_MIN);
   assign inWin     = (xRel <= XW'(X_MAX - X_MIN)) && (yRel <= YW'(Y_MAX - Y_MIN));
   assign rtlLine   = SERP_ON && line[0];
   assign pix       = (rtlLine ? shReg[0] : shReg[DW-1]) & inWin;
   assign lineInc   = line + YW'(1);
   assign nextRtl   = SERP_ON && lineInc[0];
   assign startWord = nextRtl ? WW'(WPL - 1) : '0;
   assign startX    = nextRtl ? XW'(IMG_W - 1) : '0;
   assign wordStep  = rtlLine ? wordIdx - WW'(1) : wordIdx + WW'(1);
   assign lastWord  = rtlLine ? (wordIdx == '0) : (wordIdx == WW'(WPL - 1));
   assign popC      = vld[0] & iPOS_READY;
   assign room      = (fifoCnt != NW'(FIFO_DEPTH)) || popC;
   assign pushIdx   = PW'(fifoCnt - NW'(popC));

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state    <= IDLE;
         line     <= '0;
         wordIdx  <= '0;
         xPos     <= '0;
         bitCnt   <= '0;
         shReg    <= '0;
         pen      <= 1'b0;
         penX     <= '0;
         oBusy    <= 1'b0;
         oFinish  <= 1'b0;
         oRD_REQ  <= 1'b0;
         oRD_ADDR <= '0;
         oPixCnt  <= '0;
      end else begin
         state    <= stateNxt;
         line     <= lineNxt;
         wordIdx  <= wordNxt;
         xPos     <= xNxt;
         bitCnt   <= bitNxt;
         shReg    <= shNxt;
         pen      <= penNxt;
         penX     <= penXNxt;
         oBusy    <= busyNxt;
         oFinish  <= finishNxt;
         oRD_REQ  <= rdReqNxt;
         oRD_ADDR <= rdAddrNxt;
         oPixCnt  <= pixCntNxt;
      end
   end

   always_comb begin
      stateNxt  = state;
      lineNxt   = line;
      wordNxt   = wordIdx;
      xNxt      = xPos;
      bitNxt    = bitCnt;
      shNxt     = shReg;
      penNxt    = pen;
      penXNxt   = penX;
      busyNxt   = oBusy;
      finishNxt = 1'b0;
      rdReqNxt  = oRD_REQ;
      rdAddrNxt = oRD_ADDR;
      pixCntNxt = oPixCnt;
      push      = 1'b0;
      flush     = 1'b0;
      pushX     = '0;
      pushY     = '0;
      pushDown  = 1'b0;
      if (iAbort) begin
         stateNxt = IDLE;
         flush    = 1'b1;
         penNxt   = 1'b0;
         rdReqNxt = 1'b0;
         busyNxt  = 1'b0;
      end else begin
         case (state)
            IDLE: if (iStart) begin
               stateNxt  = FETCH;
               lineNxt   = '0;
               wordNxt   = '0;
               xNxt      = '0;
               pixCntNxt = '0;
               penNxt    = 1'b0;
               busyNxt   = 1'b1;
               rdReqNxt  = 1'b1;
               rdAddrNxt = '0;
            end
            FETCH: if (iRD_VALID && oRD_REQ) begin
               shNxt    = iRD_DATA;
               bitNxt   = '0;
               rdReqNxt = 1'b0;
               stateNxt = SCAN;
            end
            // A pixel that needs a push but finds no room is re-evaluated next cycle.
            SCAN: if ((pix == pen) || room) begin
               if (pix != pen) begin
                  push     = 1'b1;
                  pushX    = pix ? CW'(xRel) : penX;
                  pushY    = CW'(yRel);
                  pushDown = pix;
               end
               penNxt = pix;
               if (pix) begin
                  pixCntNxt = oPixCnt + 20'(1);
                  penXNxt   = CW'(xRel);
               end
               shNxt  = rtlLine ? (shReg >> 1) : (shReg << 1);
               xNxt   = rtlLine ? xPos - XW'(1) : xPos + XW'(1);
               bitNxt = bitCnt + BW'(1);
               if (bitCnt == BW'(DW - 1)) begin
                  if (lastWord) begin
                     stateNxt = ROWEND;
                  end else begin
                     wordNxt   = wordStep;
                     rdAddrNxt = wordAddr(line, wordStep);
                     rdReqNxt  = 1'b1;
                     stateNxt  = FETCH;
                  end
               end
            end
            // Close any open stroke so the pen never carries across lines.
            ROWEND: if (!pen || room) begin
               if (pen) begin
                  push     = 1'b1;
                  pushX    = penX;
                  pushY    = CW'(yRel);
                  pushDown = 1'b0;
               end
               penNxt = 1'b0;
               if (line == YW'(IMG_H - 1)) begin
                  stateNxt = DRAIN;
               end else begin
                  lineNxt   = lineInc;
                  wordNxt   = startWord;
                  xNxt      = startX;
                  rdAddrNxt = wordAddr(lineInc, startWord);
                  rdReqNxt  = 1'b1;
                  stateNxt  = FETCH;
               end
            end
            DRAIN: if (fifoCnt == '0) begin
               stateNxt  = DONE;
               finishNxt = 1'b1;
               busyNxt   = 1'b0;
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
         endcase
      end
   end

   // Shift-style event FIFO: the head always lives in entry 0, so outputs come straight from flops.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         fifoCnt <= '0;
         vld     <= '0;
         memD    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            memX[i] <= '0;
            memY[i] <= '0;
         end
      end else if (flush) begin
         fifoCnt <= '0;
         vld     <= '0;
      end else begin
         if (popC) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
               memX[i] <= memX[i+1];
               memY[i] <= memY[i+1];
            end
            memD <= memD >> 1;
            vld  <= vld >> 1;
         end
         if (push) begin
            memX[pushIdx] <= pushX;
            memY[pushIdx] <= pushY;
            memD[pushIdx] <= pushDown;
            vld[pushIdx]  <= 1'b1;
         end
         fifoCnt <= fifoCnt + NW'(push) - NW'(popC);
      end
   end

   assign oPOS_VALID = vld[0];
   assign oX         = memX[0];
   assign oY         = memY[0];
   assign oDown      = memD[0];

endmodule

// File: tb/tb_bitmap_stroke_gen.sv
// Random-bitmap bench for bitmap_stroke_gen: flash responder, random-ready consumer
// and a per-pixel reference model of the expected stroke events and read order.
module tb_bitmap_stroke_gen;

   localparam int DW = 16, IMG_W = 32, IMG_H = 4, WPL = 2, NWORD = 8;
   localparam int XMIN = 8, XMAX = 31, YMIN = 0, YMAX = 2, CW = 9, DEPTH = 4, SERP = 1;

   logic          iCLK, iRST, iStart, iAbort;
   logic          oBusy, oFinish, oRD_REQ, iRD_VALID, oPOS_VALID, iPOS_READY, oDown;
   logic [19:0]   oRD_ADDR, oPixCnt;
   logic [DW-1:0] iRD_DATA;
   logic [CW-1:0] oX, oY;

   bitmap_stroke_gen #(
      .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .X_MIN(XMIN), .X_MAX(XMAX),
      .Y_MIN(YMIN), .Y_MAX(YMAX), .CW(CW), .FIFO_DEPTH(DEPTH), .SERP(SERP)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iAbort(iAbort),
      .oBusy(oBusy), .oFinish(oFinish), .oRD_REQ(oRD_REQ), .oRD_ADDR(oRD_ADDR),
      .iRD_DATA(iRD_DATA), .iRD_VALID(iRD_VALID), .oPOS_VALID(oPOS_VALID),
      .iPOS_READY(iPOS_READY), .oX(oX), .oY(oY), .oDown(oDown), .oPixCnt(oPixCnt)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   logic [15:0] img [NWORD];
   int nTests = 0, nFail = 0;
   logic [31:0] expEvt[$], expAddr[$], obsEvt[$], obsAddr[$];
   int expPix;
   int lat = -1, holdReady = 0, readyPct = 100, finCnt = 0, stableErr = 0;
   bit freezeReady = 0, prevStall = 0;
   logic [31:0] prevEvt = '0, finPix = '0;
   logic finValid = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge iCLK);
      #2;
   endtask

   function automatic logic [31:0] pack(input int x, input int y, input bit d);
      return {13'd0, x[8:0], y[8:0], d};
   endfunction

   // Reference: walk every pixel of every line in scan order and apply the pen rules.
   task automatic buildExp();
      bit rtl, pen, b, p;
      int x, lastX;
      logic [15:0] w;
      expEvt.delete();
      expAddr.delete();
      expPix = 0;
      for (int y = 0; y < IMG_H; y++) begin
         rtl = (SERP == 1) && (y % 2 == 1);
         pen = 0;
         lastX = 0;
         for (int k = 0; k < WPL; k++) expAddr.push_back(32'(y * WPL + (rtl ? WPL - 1 - k : k)));
         for (int k = 0; k < IMG_W; k++) begin
            x = rtl ? IMG_W - 1 - k : k;
            w = img[y * WPL + x / DW];
            b = w[DW - 1 - x % DW];
            p = b && x >= XMIN && x <= XMAX && y >= YMIN && y <= YMAX;
            if (p && !pen) begin
               expEvt.push_back(pack(x - XMIN, y - YMIN, 1'b1));
               pen = 1;
            end else if (!p && pen) begin
               expEvt.push_back(pack(lastX - XMIN, y - YMIN, 1'b0));
               pen = 0;
            end
            if (p) begin
               expPix++;
               lastX = x;
            end
         end
         if (pen) expEvt.push_back(pack(lastX - XMIN, y - YMIN, 1'b0));
      end
   endtask

   // Flash responder, consumer and output monitor share one negedge process.
   initial forever begin
      @(negedge iCLK);
      if (oRD_REQ) begin
         if (lat < 0) lat = $urandom_range(0, 3);
         if (lat == 0) begin
            iRD_VALID = 1'b1;
            iRD_DATA  = img[int'(oRD_ADDR) % NWORD];
            obsAddr.push_back(32'(oRD_ADDR));
            lat = -1;
         end else begin
            iRD_VALID = 1'b0;
            lat--;
         end
      end else begin
         lat = -1;
         iRD_VALID = ($urandom_range(0, 3) == 0);
         iRD_DATA  = 16'($urandom);
      end
      if (freezeReady) iPOS_READY = 1'b0;
      else if (holdReady > 0) begin
         iPOS_READY = 1'b0;
         holdReady--;
      end else iPOS_READY = ($urandom_range(0, 99) < readyPct);
      if (prevStall && oPOS_VALID && ({13'd0, oX, oY, oDown} != prevEvt)) stableErr++;
      prevStall = oPOS_VALID && !iPOS_READY;
      prevEvt   = {13'd0, oX, oY, oDown};
      if (oPOS_VALID && iPOS_READY) obsEvt.push_back({13'd0, oX, oY, oDown});
      if (oFinish) begin
         finCnt++;
         finPix   = 32'(oPixCnt);
         finValid = oPOS_VALID;
      end
   end

   task automatic runFrame(input string tag, input int hold, input int pct, input bit restart);
      int cyc;
      int n;
      buildExp();
      obsEvt.delete();
      obsAddr.delete();
      finCnt = 0;
      stableErr = 0;
      holdReady = hold;
      readyPct = pct;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      checkVal({tag, "_busy"}, 32'(oBusy), 1);
      for (cyc = 0; cyc < 4000 && finCnt == 0; cyc++) begin
         iStart = (restart && cyc == 20);
         tick();
      end
      iStart = 1'b0;
      checkVal({tag, "_finished"}, 32'(finCnt != 0), 1);
      repeat (3) tick();
      checkVal({tag, "_finPulses"}, 32'(finCnt), 1);
      checkVal({tag, "_emptyAtFin"}, 32'(finValid), 0);
      checkVal({tag, "_busyEnd"}, 32'(oBusy), 0);
      checkVal({tag, "_pixCnt"}, finPix, 32'(expPix));
      checkVal({tag, "_stable"}, 32'(stableErr), 0);
      checkVal({tag, "_nAddr"}, 32'(obsAddr.size()), 32'(expAddr.size()));
      n = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
      for (int i = 0; i < n; i++) checkVal({tag, "_addr"}, obsAddr[i], expAddr[i]);
      checkVal({tag, "_nEvt"}, 32'(obsEvt.size()), 32'(expEvt.size()));
      n = (obsEvt.size() < expEvt.size()) ? obsEvt.size() : expEvt.size();
      for (int i = 0; i < n; i++) checkVal({tag, "_evt"}, obsEvt[i], expEvt[i]);
   endtask

   task automatic fillImg(input logic [15:0] v);
      for (int i = 0; i < NWORD; i++) img[i] = v;
   endtask

   task automatic checkOutputsZero(input string tag);
      checkVal({tag, "_ctl"}, 32'({oBusy, oFinish, oRD_REQ, oPOS_VALID, oDown}), 0);
      checkVal({tag, "_addr"}, 32'(oRD_ADDR), 0);
      checkVal({tag, "_pix"}, 32'(oPixCnt), 0);
      checkVal({tag, "_xy"}, 32'({oX, oY}), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      iRST = 1'b0; iStart = 1'b0; iAbort = 1'b0;
      iRD_VALID = 1'b0; iRD_DATA = '0; iPOS_READY = 1'b0;
      fillImg(16'h0000);
      repeat (3) tick();
      checkOutputsZero("rst");
      iRST = 1'b1;
      tick();

      runFrame("blank", 0, 100, 0);
      fillImg(16'h0000); img[0] = 16'h00F0;
      runFrame("run4", 0, 100, 0);
      fillImg(16'h0000);
      img[0] = 16'hFF80; img[3] = 16'h0001; img[5] = 16'h0001; img[6] = 16'hFFFF; img[7] = 16'hFFFF;
      runFrame("edges", 0, 80, 0);
      fillImg(16'hFFFF);
      runFrame("full", 0, 70, 1);
      fillImg(16'hAAAA);
      runFrame("bkpr", 50, 50, 0);

      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < NWORD; i++) begin
            case ($urandom_range(0, 3))
               0: img[i] = 16'($urandom & $urandom & $urandom);
               1: img[i] = 16'($urandom);
               2: img[i] = 16'($urandom | $urandom);
               default: img[i] = 16'hFFFF << $urandom_range(0, 15);
            endcase
         end
         runFrame("rand", (f % 4 == 0) ? 30 : 0, $urandom_range(20, 100), f[0]);
      end

      // Abort with events queued and the consumer stalled.
      fillImg(16'h0000); img[0] = 16'h0055;
      freezeReady = 1;
      finCnt = 0;
      iStart = 1'b1; tick(); iStart = 1'b0;
      for (cyc = 0; cyc < 200 && !oPOS_VALID; cyc++) tick();
      repeat (3) tick();
      checkVal("abort_queued", 32'(oPOS_VALID), 1);
      iAbort = 1'b1; tick(); iAbort = 1'b0;
      checkVal("abort_valid", 32'(oPOS_VALID), 0);
      checkVal("abort_busy", 32'(oBusy), 0);
      checkVal("abort_req", 32'(oRD_REQ), 0);
      repeat (30) tick();
      checkVal("abort_noFin", 32'(finCnt), 0);
      freezeReady = 0;
      fillImg(16'h0000); img[2] = 16'h0F0F; img[4] = 16'h8001;
      runFrame("postAbort", 0, 90, 0);

      // Reset while fetching the first word of line 1.
      fillImg(16'h3C3C);
      iStart = 1'b1; tick(); iStart = 1'b0;
      for (cyc = 0; cyc < 300 && !(oRD_REQ && oRD_ADDR == 20'd3); cyc++) tick();
      checkVal("rstMid_reached", 32'(oRD_REQ && oRD_ADDR == 20'd3), 1);
      iRST = 1'b0;
      #1;
      checkOutputsZero("rstMid");
      tick();
      iRST = 1'b1;
      tick();
      runFrame("postRst", 0, 100, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
